// File: rtl/pp_dispatch_if.sv
// Ingress chunk stream and shared parser bus of the path-parser dispatcher.
//   in_*      : ingress beat stream (valid/ready), in_meta_rci sampled on sop
//   pp_ready  : per-parser path_parser_ready
//   pp_*      : registered beat/metadata bus towards the parsers
//   len_err   : packet truncated at the chunk-buffer limit
//   sop_err   : sop seen where it is not expected
// master = traffic source / parser side, slave = dispatcher.
interface pp_dispatch_if #(
   parameter int unsigned NUM_PP     = 4,
   parameter int unsigned DATA_NBITS = 64,
   parameter int unsigned RCI_NBITS  = 8
);
   logic                  in_valid;
   logic [DATA_NBITS-1:0] in_data;
   logic                  in_sop;
   logic                  in_eop;
   logic [RCI_NBITS-1:0]  in_meta_rci;
   logic                  in_ready;
   logic [NUM_PP-1:0]     pp_ready;
   logic                  pp_valid;
   logic [DATA_NBITS-1:0] pp_data;
   logic                  pp_eop;
   logic [1:0]            pp_id;
   logic                  pp_meta_valid;
   logic [RCI_NBITS-1:0]  pp_meta_rci;
   logic                  len_err;
   logic                  sop_err;

   modport master (
      output in_valid, in_data, in_sop, in_eop, in_meta_rci, pp_ready,
      input  in_ready, pp_valid, pp_data, pp_eop, pp_id, pp_meta_valid, pp_meta_rci,
             len_err, sop_err
   );

   modport slave (
      input  in_valid, in_data, in_sop, in_eop, in_meta_rci, pp_ready,
      output in_ready, pp_valid, pp_data, pp_eop, pp_id, pp_meta_valid, pp_meta_rci,
             len_err, sop_err
   );
endinterface

// File: rtl/pp_dispatch.sv
// Path-parser dispatcher. Schedules each ingress packet onto one of NUM_PP parsers
// (round-robin among ready, non-locked parsers), forwards its beats with one cycle
// of latency, truncates packets at MAX_BEATS and emits the metadata beat.
// Ports:
//   clk  : clock
//   rstn : asynchronous reset, active low
//   bus  : pp_dispatch_if.slave (ingress stream, pp_ready, parser bus, error pulses)
module pp_dispatch #(
   parameter int unsigned NUM_PP     = 4,
   parameter int unsigned DATA_NBITS = 64,
   parameter int unsigned RCI_NBITS  = 8,
   parameter int unsigned MAX_BEATS  = 8,
   parameter int unsigned LOCKOUT    = 4
) (
   input logic          clk,
   input logic          rstn,
   pp_dispatch_if.slave bus
);
   localparam int unsigned CNT_NBITS = $clog2(MAX_BEATS) + 1;

   typedef enum logic [1:0] {StIdle, StXfer, StDrop} state_e;

   state_e                state_q, state_d;
   logic [1:0]            rr_q, rr_d;
   logic [1:0]            cur_q, cur_d;
   logic [CNT_NBITS-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [3:0]            lock_q [4];

   logic                  pp_valid_q, pp_eop_q, meta_valid_q, len_err_q, sop_err_q;
   logic [DATA_NBITS-1:0] pp_data_q;
   logic [1:0]            pp_id_q;
   logic [RCI_NBITS-1:0]  meta_rci_q;

   logic [3:0] eligible;
   logic       win_found;
   logic [1:0] win_id, idx;
   logic       ready, accept;
   logic       fwd, fwd_eop, fwd_meta, len_err_d, sop_err_d, load;
   logic [1:0] fwd_id;

   always_comb begin
      eligible = '0;
      for (int k = 0; k < int'(NUM_PP); k++) begin
         eligible[k] = bus.pp_ready[k] && (lock_q[k] == 4'd0);
      end
   end

   // First eligible parser searching from rr_q upwards, modulo NUM_PP.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = '0;
      for (int i = 0; i < int'(NUM_PP); i++) begin
         idx = 2'((int'(rr_q) + i) % int'(NUM_PP));
         if (!win_found && eligible[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   // Gated by rstn so nothing is accepted while reset is held.
   assign ready  = rstn && ((state_q == StIdle) ? win_found : 1'b1);
   assign accept = bus.in_valid && ready;

   assign cnt_inc = (cnt_q == CNT_NBITS'(MAX_BEATS)) ? cnt_q : cnt_q + CNT_NBITS'(1);

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      cur_d     = cur_q;
      cnt_d     = cnt_q;
      fwd       = 1'b0;
      fwd_eop   = 1'b0;
      fwd_meta  = 1'b0;
      fwd_id    = cur_q;
      len_err_d = 1'b0;
      sop_err_d = 1'b0;
      load      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (bus.in_sop) begin
                  fwd      = 1'b1;
                  fwd_meta = 1'b1;
                  fwd_id   = win_id;
                  cur_d    = win_id;
                  rr_d     = (win_id == 2'(NUM_PP - 1)) ? 2'd0 : win_id + 2'd1;
                  cnt_d    = CNT_NBITS'(1);
                  if (bus.in_eop) begin
                     fwd_eop = 1'b1;
                     load    = 1'b1;
                  end else begin
                     state_d = StXfer;
                  end
               end else begin
                  sop_err_d = 1'b1;
               end
            end
         end
         StXfer: begin
            if (accept) begin
               fwd       = 1'b1;
               sop_err_d = bus.in_sop;
               cnt_d     = cnt_inc;
               if (bus.in_eop) begin
                  fwd_eop = 1'b1;
                  load    = 1'b1;
                  state_d = StIdle;
               end else if (cnt_inc == CNT_NBITS'(MAX_BEATS)) begin
                  // Buffer half full: close the packet and drop the tail.
                  fwd_eop   = 1'b1;
                  load      = 1'b1;
                  len_err_d = 1'b1;
                  state_d   = StDrop;
               end
            end
         end
         StDrop: begin
            if (accept && bus.in_eop) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         rr_q         <= '0;
         cur_q        <= '0;
         cnt_q        <= '0;
         pp_valid_q   <= 1'b0;
         pp_eop_q     <= 1'b0;
         meta_valid_q <= 1'b0;
         len_err_q    <= 1'b0;
         sop_err_q    <= 1'b0;
         pp_data_q    <= '0;
         pp_id_q      <= '0;
         meta_rci_q   <= '0;
         for (int k = 0; k < 4; k++) lock_q[k] <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         cur_q        <= cur_d;
         cnt_q        <= cnt_d;
         pp_valid_q   <= fwd;
         pp_eop_q     <= fwd_eop;
         meta_valid_q <= fwd_meta;
         len_err_q    <= len_err_d;
         sop_err_q    <= sop_err_d;
         if (fwd) begin
            pp_data_q <= bus.in_data;
            pp_id_q   <= fwd_id;
         end
         if (fwd_meta) meta_rci_q <= bus.in_meta_rci;
         // Load on the eop beat takes priority over the per-cycle decrement.
         for (int k = 0; k < 4; k++) begin
            if (load && (fwd_id == 2'(k))) begin
               lock_q[k] <= 4'(LOCKOUT);
            end else if (lock_q[k] != 4'd0) begin
               lock_q[k] <= lock_q[k] - 4'd1;
            end
         end
      end
   end

   assign bus.in_ready      = ready;
   assign bus.pp_valid      = pp_valid_q;
   assign bus.pp_data       = pp_data_q;
   assign bus.pp_eop        = pp_eop_q;
   assign bus.pp_id         = pp_id_q;
   assign bus.pp_meta_valid = meta_valid_q;
   assign bus.pp_meta_rci   = meta_rci_q;
   assign bus.len_err       = len_err_q;
   assign bus.sop_err       = sop_err_q;
endmodule

// File: tb/tb_pp_dispatch.sv
// Bench for pp_dispatch: directed scenarios plus random traffic, scored against a
// cycle-stamped reference model of dispatch, lockout and truncation rules.
module tb_pp_dispatch;
   localparam int NPP = 4;
   localparam int DW  = 16;
   localparam int RW  = 4;
   localparam int MAXB = 8;
   localparam int LOCK = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   pp_dispatch_if #(.NUM_PP(NPP), .DATA_NBITS(DW), .RCI_NBITS(RW)) bus ();

   pp_dispatch #(
      .NUM_PP(NPP), .DATA_NBITS(DW), .RCI_NBITS(RW), .MAX_BEATS(MAXB), .LOCKOUT(LOCK)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            at;
      bit            v;
      bit            eop;
      logic [1:0]    id;
      bit            meta;
      logic [RW-1:0] rci;
      bit            lerr;
      bit            serr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state
   int            m_mode;   // 0 waiting for sop, 1 in packet, 2 dropping tail
   int            m_rr, m_cur, m_nbeats;
   int            m_free_at[NPP];
   logic [DW-1:0] m_last_data;
   logic [1:0]    m_last_id;
   logic [RW-1:0] m_last_rci;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      m_mode = 0; m_rr = 0; m_cur = 0; m_nbeats = 0;
      for (int k = 0; k < NPP; k++) m_free_at[k] = 0;
      m_last_data = '0; m_last_id = '0; m_last_rci = '0;
   endtask

   // One cycle: apply inputs, check in_ready, update model and expectations.
   task automatic drive(input bit iv, input bit sop, input bit eop, input logic [DW-1:0] d,
                        input logic [RW-1:0] rci, input logic [NPP-1:0] rdy, output bit acc);
      bit   exp_rdy;
      int   w;
      exp_t it;
      bus.in_valid = iv; bus.in_sop = sop; bus.in_eop = eop;
      bus.in_data = d; bus.in_meta_rci = rci; bus.pp_ready = rdy;
      @(negedge clk);
      w = -1;
      for (int i = 0; i < NPP; i++) begin
         int k;
         k = (m_rr + i) % NPP;
         if (w < 0 && rdy[k] && cyc >= m_free_at[k]) w = k;
      end
      exp_rdy = (m_mode != 0) || (w >= 0);
      check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      acc = iv && exp_rdy;
      it = '{at: cyc + 1, v: 0, eop: 0, id: m_last_id, meta: 0, rci: m_last_rci,
             lerr: 0, serr: 0, data: m_last_data};
      if (acc) begin
         if (m_mode == 0) begin
            if (sop) begin
               it.v = 1; it.meta = 1; it.rci = rci; it.id = 2'(w);
               m_cur = w; m_rr = (w + 1) % NPP; m_nbeats = 1;
               if (eop) begin
                  it.eop = 1; m_free_at[w] = cyc + LOCK + 1;
               end else begin
                  m_mode = 1;
               end
            end else begin
               it.serr = 1;
            end
         end else if (m_mode == 1) begin
            it.v = 1; it.id = 2'(m_cur); it.serr = sop;
            m_nbeats++;
            if (eop || m_nbeats == MAXB) begin
               it.eop = 1; it.lerr = !eop;
               m_free_at[m_cur] = cyc + LOCK + 1;
               m_mode = eop ? 0 : 2;
            end
         end else if (eop) begin
            m_mode = 0;
         end
      end
      if (it.v) begin
         it.data = d; m_last_data = d; m_last_id = it.id;
      end
      if (it.meta) m_last_rci = rci;
      if (it.v || it.lerr || it.serr) exp_q.push_back(it);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit sop, input bit eop, input logic [DW-1:0] d,
                       input logic [RW-1:0] rci, input logic [NPP-1:0] rdy);
      bit acc;
      acc = 0;
      for (int n = 0; n < 40 && !acc; n++) drive(1, sop, eop, d, rci, rdy, acc);
      if (!acc) begin
         n_checks++;
         $display("FAIL send_timeout: beat %0h never accepted (cycle %0d)", d, cyc);
      end
   endtask

   task automatic idle(input int n, input logic [NPP-1:0] rdy);
      bit acc;
      for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, rdy, acc);
   endtask

   // Monitor: every cycle the DUT presents something, pop and compare.
   always @(negedge clk) begin
      if (rstn && (bus.pp_valid || bus.len_err || bus.sop_err)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(1), 64'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_vec",
                  {24'd0, bus.pp_valid, bus.pp_eop, bus.pp_id, bus.pp_meta_valid,
                   bus.len_err, bus.sop_err, bus.pp_meta_rci, bus.pp_data},
                  {24'd0, e.v, e.eop, e.id, e.meta, e.lerr, e.serr, e.rci, e.data});
            check("out_latency", 64'(cyc), 64'(e.at));
         end
      end
   end

   initial begin
      bit acc;
      int pos, len;
      logic [NPP-1:0] rdy;
      model_reset();
      bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0;
      bus.in_data = '0; bus.in_meta_rci = '0; bus.pp_ready = '1;
      #1;
      check("reset_outputs",
            {bus.in_ready, bus.pp_valid, bus.pp_eop, bus.pp_id, bus.pp_meta_valid,
             bus.len_err, bus.sop_err, bus.pp_meta_rci, bus.pp_data}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rstn = 1;

      // Four 3-beat packets back to back onto parsers 0..3.
      for (int p = 0; p < 4; p++)
         for (int b = 0; b < 3; b++)
            send(b == 0, b == 2, DW'(16'h1000 + p * 16 + b), RW'(p + 1), 4'b1111);

      // Only parser 2 ready: second packet waits out the lockout.
      send(1, 1, 16'h2001, 4'h7, 4'b0100);
      send(1, 1, 16'h2002, 4'h8, 4'b0100);

      // Overlong packet: truncated at MAXB, tail dropped, then a normal packet.
      for (int b = 0; b < MAXB + 3; b++)
         send(b == 0, b == MAXB + 2, DW'(16'h3000 + b), 4'h9, 4'b1111);
      send(1, 1, 16'h3100, 4'ha, 4'b1111);

      // Stray sop on beat 2 of a 4-beat packet.
      for (int b = 0; b < 4; b++)
         send(b == 0 || b == 1, b == 3, DW'(16'h4000 + b), 4'hb, 4'b1111);

      // No parser ready: held sop, then parser 1 raises ready.
      idle(LOCK + 2, 4'b1111);
      drive(1, 1, 1, 16'h5000, 4'hc, 4'b0000, acc);
      drive(1, 1, 1, 16'h5000, 4'hc, 4'b0000, acc);
      drive(1, 1, 1, 16'h5000, 4'hc, 4'b0010, acc);
      check("late_ready_accept", 64'(acc), 64'(1));

      // Reset during beat 2 of 5.
      idle(LOCK + 2, 4'b1111);
      send(1, 0, 16'h6000, 4'hd, 4'b1111);
      send(0, 0, 16'h6001, 4'hd, 4'b1111);
      rstn = 0;
      exp_q.delete();
      model_reset();
      #1;
      check("async_reset_outputs",
            {bus.in_ready, bus.pp_valid, bus.pp_eop, bus.pp_id, bus.pp_meta_valid,
             bus.len_err, bus.sop_err, bus.pp_meta_rci, bus.pp_data}, 64'd0);
      @(posedge clk);
      #1 rstn = 1;
      for (int b = 2; b < 5; b++) send(0, b == 4, DW'(16'h6000 + b), 4'hd, 4'b1111);
      send(1, 1, 16'h6100, 4'he, 4'b1111);

      // Random traffic, lengths up to MAXB+3, occasional sop errors.
      pos = 0;
      len = 1;
      rdy = 4'b1111;
      for (int n = 0; n < 1500; n++) begin
         bit iv, sop;
         if ($urandom_range(0, 7) == 0) rdy = NPP'($urandom_range(0, 15));
         if (pos == 0) len = $urandom_range(1, MAXB + 3);
         iv  = ($urandom_range(0, 3) != 0);
         sop = (pos == 0) ^ ($urandom_range(0, 19) == 0);
         drive(iv, sop, pos == len - 1, DW'($urandom), RW'($urandom), rdy, acc);
         if (acc) pos = (pos == len - 1) ? 0 : pos + 1;
      end

      idle(4, 4'b1111);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/pp_dispatch.md
# pp_dispatch

Path-parser dispatcher: accepts the path-header chunk stream from the ingress pipeline and schedules each packet onto one of NUM_PP path-parser instances over the shared pp_* bus. Selection is round-robin among parsers reporting path_parser_ready. A per-parser lockout covers the parser's registered ready latency. The block also enforces the chunk-buffer length limit and issues the per-packet metadata beat.

## Interface
- NUM_PP, 4, number of parser instances, 2..4; pp_id is 2 bits.
- DATA_NBITS, `DATA_PATH_NBITS, chunk data width.
- RCI_NBITS, `PP_META_RCI_NBITS, metadata RCI width.
- MAX_BEATS, 2**`PATH_CHUNK_DEPTH_NBITS, maximum beats per packet (one parser buffer half).
- LOCKOUT, 4, cycles a parser stays ineligible after its packet's last beat, 1..15.

Ports:
- clk  in  1  clock.
- `RESET_SIG` (rstn)  in  1  asynchronous reset, active-low.
- in_valid  in  1  ingress beat valid.
- in_data  in  DATA_NBITS  ingress beat data.
- in_sop  in  1  first beat of packet.
- in_eop  in  1  last beat of packet.
- in_meta_rci  in  RCI_NBITS  RCI; sampled on the sop beat only.
- in_ready  out  1  ingress accept; a beat transfers when in_valid & in_ready.
- pp_ready  in  NUM_PP  path_parser_ready from each parser, bit k = parser k.
- pp_valid  out  1  beat to the parser bus.
- pp_data  out  DATA_NBITS  beat data.
- pp_eop  out  1  last beat to the parser.
- pp_id  out  2  target parser.
- pp_meta_valid  out  1  metadata strobe; coincides with the packet's first pp_valid beat.
- pp_meta_rci  out  RCI_NBITS  metadata RCI.
- len_err  out  1  one-cycle pulse when the packet was truncated at MAX_BEATS.
- sop_err  out  1  one-cycle pulse when in_sop arrives mid-packet.

## Operation
- States: IDLE, XFER, DROP.
- eligible[k] = pp_ready[k] & (lock_cnt[k]==0).
- Winner: first eligible index searching rr_ptr, rr_ptr+1, … modulo NUM_PP.

Per state:
- IDLE: in_ready = |eligible.
  - A non-sop beat accepted in IDLE is discarded and pulses sop_err. It is consumed only when some parser is eligible.
  - sop beat accepted: latch cur_id = winner, set rr_ptr = (winner+1) mod NUM_PP, beat_cnt = 1, forward the beat with pp_meta_valid=1.
  - If in_eop is also set, stay in IDLE. Otherwise go to XFER.
- XFER: in_ready = 1. Each accepted beat is forwarded to cur_id and increments beat_cnt.
  - in_eop: forward with pp_eop=1, go to IDLE.
  - beat_cnt reaches MAX_BEATS with in_eop=0: forward that beat with pp_eop=1 forced, pulse len_err, go to DROP.
  - in_sop in XFER: treated as data, pulses sop_err.
- DROP: in_ready = 1. Accepted beats are discarded. The eop beat returns the block to IDLE.

Lockout:
- Every forwarded pp_eop beat loads lock_cnt[cur_id] = LOCKOUT.
- Each nonzero lock_cnt decrements by 1 per cycle. A load wins over a decrement.

Output rules:
- pp_meta_rci holds its last value when pp_meta_valid=0.
- pp_data and pp_id hold their last values when pp_valid=0.

Width rules:
- beat_cnt is clog2(MAX_BEATS)+1 bits, saturating; no wrap.
- rr_ptr is 2 bits and wraps to 0 at NUM_PP.

## Timing
- Forwarding latency: 1 cycle. An input beat accepted at cycle t appears on pp_* at t+1. All pp_* outputs, len_err and sop_err are registered.
- in_ready is combinational from state, lock_cnt and pp_ready. It has no dependency on in_valid.
- Throughput: 1 beat per cycle within a packet. Minimum packet-to-packet gap: 0 cycles. After the eop beat, an IDLE sop can be accepted the next cycle by a different eligible parser.
- The same parser is re-eligible no earlier than LOCKOUT+1 cycles after its eop beat is forwarded.
- pp_ready changes during XFER or DROP do not affect the packet in flight; a parser is never switched mid-packet.
- Reset (asynchronous, any state):
  - state = IDLE; rr_ptr = 0; lock_cnt = 0; beat_cnt = 0.
  - pp_valid, pp_eop, pp_meta_valid, len_err, sop_err = 0.
  - pp_data, pp_id, pp_meta_rci = 0.
  - in_ready = 0 while reset is asserted.
  - A packet in flight at reset is abandoned; nothing further is emitted for it.
- Release: the first accept is possible the cycle after rstn rises, provided pp_ready is nonzero.

## Test plan
- pp_ready=4'b1111, four 3-beat packets back-to-back -> pp_id 0,1,2,3 in order; pp_meta_valid on each first beat; 12 consecutive pp_valid cycles; each beat appears 1 cycle after acceptance.
- pp_ready=4'b0100, two single-beat sop+eop packets -> first goes to pp_id=2. in_ready stays 0 for 4 cycles (LOCKOUT), then the second also goes to pp_id=2.
- Packet of MAX_BEATS+3 beats -> MAX_BEATS beats forwarded, the last with pp_eop=1; len_err pulses once; 3 beats consumed with no pp_valid; next sop dispatches normally.
- in_sop on beat 2 of a 4-beat packet -> all 4 beats forwarded to the same pp_id; sop_err pulses once, 1 cycle after beat 2 is accepted.
- pp_ready=0 with in_valid held on a sop beat -> in_ready=0, no pp_valid. Raise pp_ready[1] -> accepted the same cycle, pp_id=1 one cycle later.
- Assert rstn=0 mid-XFER (beat 2 of 5) -> all outputs 0 immediately; after release, remaining beats without sop are discarded with sop_err; a fresh packet goes to pp_id=0.
